// File: rtl/pc_sequencer_if.sv
// Decoder/adder-facing signal bundle for the mc6502 PC sequencer.
// The slave modport is the sequencer's view; master is the surrounding CPU/adder view.
interface pc_sequencer_if;
  logic       STEP;
  logic       INC_REQ;
  logic       BR_REQ;
  logic       BR_COND;
  logic [7:0] OFFSET;
  logic       LOAD_REQ;
  logic [7:0] LOAD_ADL;
  logic [7:0] LOAD_ADH;
  logic       ADDER_RES_N;
  logic [7:0] ADDER_IL;
  logic [7:0] ADDER_IH;
  logic [7:0] ADDER_SRC;
  logic [1:0] ADDER_CTRL;
  logic [7:0] ADDER_OL;
  logic [7:0] ADDER_OH;
  logic       ADDER_CARRY;
  logic [7:0] PCL;
  logic [7:0] PCH;
  logic       BUSY;
  logic       BR_DONE;
  logic       PAGE_CROSS;

  modport slave (
    input  STEP, INC_REQ, BR_REQ, BR_COND, OFFSET, LOAD_REQ, LOAD_ADL, LOAD_ADH,
    input  ADDER_OL, ADDER_OH, ADDER_CARRY,
    output ADDER_RES_N, ADDER_IL, ADDER_IH, ADDER_SRC, ADDER_CTRL,
    output PCL, PCH, BUSY, BR_DONE, PAGE_CROSS
  );

  modport master (
    output STEP, INC_REQ, BR_REQ, BR_COND, OFFSET, LOAD_REQ, LOAD_ADL, LOAD_ADH,
    output ADDER_OL, ADDER_OH, ADDER_CARRY,
    input  ADDER_RES_N, ADDER_IL, ADDER_IH, ADDER_SRC, ADDER_CTRL,
    input  PCL, PCH, BUSY, BR_DONE, PAGE_CROSS
  );
endinterface

// File: rtl/pc_sequencer.sv
// Owns the 16-bit PC and steers the external PC adder through increment, load
// and relative-branch operations, including the page-crossing high-byte fix.
module pc_sequencer #(
  parameter logic [15:0] PC_RESET  = 16'hFFFC,
  parameter logic [1:0]  CTRL_HOLD = 2'd0,
  parameter logic [1:0]  CTRL_INC  = 2'd1,
  parameter logic [1:0]  CTRL_ADD  = 2'd2,
  parameter logic [1:0]  CTRL_CADD = 2'd3
) (
  input  logic            CLK,
  input  logic            RES,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] pcl_q, pcl_next;
  logic [7:0] pch_q, pch_next;
  logic [7:0] offset_q, offset_next;
  logic       dir_down_q, dir_down_next;
  logic       br_done_q, br_done_next;
  logic       page_cross_q, page_cross_next;
  logic       neg;
  logic       cross_up;
  logic       cross_down;

  assign neg        = offset_q[7];
  assign cross_up   = !neg && bus.ADDER_CARRY;
  assign cross_down = neg && !bus.ADDER_CARRY;

  always_ff @(posedge CLK) begin
    if (RES) begin
      state        <= IDLE;
      pcl_q        <= PC_RESET[7:0];
      pch_q        <= PC_RESET[15:8];
      offset_q     <= 8'h00;
      dir_down_q   <= 1'b0;
      br_done_q    <= 1'b0;
      page_cross_q <= 1'b0;
    end else begin
      state        <= state_next;
      pcl_q        <= pcl_next;
      pch_q        <= pch_next;
      offset_q     <= offset_next;
      dir_down_q   <= dir_down_next;
      br_done_q    <= br_done_next;
      page_cross_q <= page_cross_next;
    end
  end

  // Pulse registers default to 0, so a stalled cycle clears any pending pulse.
  always_comb begin
    state_next      = state;
    pcl_next        = pcl_q;
    pch_next        = pch_q;
    offset_next     = offset_q;
    dir_down_next   = dir_down_q;
    br_done_next    = 1'b0;
    page_cross_next = 1'b0;
    bus.ADDER_CTRL  = CTRL_HOLD;

    if (bus.STEP) begin
      unique case (state)
        IDLE: begin
          if (bus.LOAD_REQ) begin
            pcl_next = bus.LOAD_ADL;
            pch_next = bus.LOAD_ADH;
          end else if (bus.BR_REQ) begin
            if (bus.BR_COND) begin
              offset_next = bus.OFFSET;
              state_next  = ADD;
            end else begin
              bus.ADDER_CTRL = CTRL_INC;
              pcl_next       = bus.ADDER_OL;
              pch_next       = bus.ADDER_OH;
              br_done_next   = 1'b1;
            end
          end else if (bus.INC_REQ) begin
            bus.ADDER_CTRL = CTRL_INC;
            pcl_next       = bus.ADDER_OL;
            pch_next       = bus.ADDER_OH;
          end
        end

        ADD: begin
          bus.ADDER_CTRL = CTRL_ADD;
          pcl_next       = bus.ADDER_OL;
          if (cross_up || cross_down) begin
            dir_down_next = cross_down;
            state_next    = FIX;
          end else begin
            br_done_next = 1'b1;
            state_next   = IDLE;
          end
        end

        FIX: begin
          // Backward crossings borrow locally; the adder only knows how to add carry.
          if (dir_down_q) begin
            pch_next = pch_q - 8'd1;
          end else begin
            bus.ADDER_CTRL = CTRL_CADD;
            pch_next       = bus.ADDER_OH;
          end
          br_done_next    = 1'b1;
          page_cross_next = 1'b1;
          state_next      = IDLE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.ADDER_SRC   = (state == ADD) ? offset_q : 8'h00;
  assign bus.BUSY        = (state != IDLE);
  assign bus.ADDER_RES_N = ~RES;
  assign bus.ADDER_IL    = pcl_q;
  assign bus.ADDER_IH    = pch_q;
  assign bus.PCL         = pcl_q;
  assign bus.PCH         = pch_q;
  assign bus.BR_DONE     = br_done_q;
  assign bus.PAGE_CROSS  = page_cross_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC adder attached to its adder port.
module tb_pc_sequencer;

  localparam logic [1:0] HOLD = 2'd0;
  localparam logic [1:0] INC  = 2'd1;
  localparam logic [1:0] ADDC = 2'd2;
  localparam logic [1:0] CADD = 2'd3;

  logic CLK = 1'b0;
  logic RES = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic cap_carry;
  logic [8:0] low_sum;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  // Behavioural adder: combinational result, carry captured on an ADD cycle.
  always_comb begin
    low_sum         = {1'b0, bus.ADDER_IL} + 9'd1 + {1'b0, bus.ADDER_SRC};
    bus.ADDER_OL    = bus.ADDER_IL;
    bus.ADDER_OH    = bus.ADDER_IH;
    bus.ADDER_CARRY = 1'b0;
    case (bus.ADDER_CTRL)
      INC:  {bus.ADDER_OH, bus.ADDER_OL} = {bus.ADDER_IH, bus.ADDER_IL} + 16'd1;
      ADDC: begin
        bus.ADDER_OL    = low_sum[7:0];
        bus.ADDER_CARRY = low_sum[8];
      end
      CADD: bus.ADDER_OH = bus.ADDER_IH + {7'd0, cap_carry};
      default: ;
    endcase
  end

  always @(posedge CLK) begin
    if (RES) cap_carry <= 1'b0;
    else if (bus.STEP && bus.ADDER_CTRL == ADDC) cap_carry <= low_sum[8];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] pc);
    bus.LOAD_REQ = 1'b1;
    bus.LOAD_ADL = pc[7:0];
    bus.LOAD_ADH = pc[15:8];
    tick();
    bus.LOAD_REQ = 1'b0;
  endtask

  task automatic startBranch(input logic cond, input logic [7:0] off);
    bus.BR_REQ  = 1'b1;
    bus.BR_COND = cond;
    bus.OFFSET  = off;
  endtask

  initial begin
    bus.STEP = 1'b1; bus.INC_REQ = 1'b0; bus.BR_REQ = 1'b0; bus.BR_COND = 1'b0;
    bus.OFFSET = 8'h00; bus.LOAD_REQ = 1'b0; bus.LOAD_ADL = 8'h00; bus.LOAD_ADH = 8'h00;

    tick(); tick();
    checkOutput("res_n_low", {15'd0, bus.ADDER_RES_N}, 16'd0);
    RES = 1'b0;
    #1;
    checkOutput("reset_pc", {bus.PCH, bus.PCL}, 16'hFFFC);
    checkOutput("reset_busy", {15'd0, bus.BUSY}, 16'd0);
    checkOutput("reset_ctrl", {14'd0, bus.ADDER_CTRL}, {14'd0, HOLD});
    checkOutput("reset_done", {15'd0, bus.BR_DONE}, 16'd0);
    checkOutput("res_n_high", {15'd0, bus.ADDER_RES_N}, 16'd1);

    bus.LOAD_REQ = 1'b1; bus.LOAD_ADL = 8'h00; bus.LOAD_ADH = 8'h80;
    #1 checkOutput("load_ctrl", {14'd0, bus.ADDER_CTRL}, {14'd0, HOLD});
    tick(); bus.LOAD_REQ = 1'b0;
    checkOutput("load_pc", {bus.PCH, bus.PCL}, 16'h8000);

    applyStimulus(16'hFFFF);
    bus.INC_REQ = 1'b1;
    #1 checkOutput("inc_ctrl", {14'd0, bus.ADDER_CTRL}, {14'd0, INC});
    tick(); bus.INC_REQ = 1'b0;
    checkOutput("inc_wrap", {bus.PCH, bus.PCL}, 16'h0000);

    applyStimulus(16'h8010);
    startBranch(1'b0, 8'h05);
    #1 checkOutput("nt_ctrl", {14'd0, bus.ADDER_CTRL}, {14'd0, INC});
    tick(); bus.BR_REQ = 1'b0;
    checkOutput("nt_pc", {bus.PCH, bus.PCL}, 16'h8011);
    checkOutput("nt_done", {15'd0, bus.BR_DONE}, 16'd1);
    checkOutput("nt_cross", {15'd0, bus.PAGE_CROSS}, 16'd0);
    tick();
    checkOutput("nt_done_clr", {15'd0, bus.BR_DONE}, 16'd0);

    applyStimulus(16'h8010);
    startBranch(1'b1, 8'h05);
    #1 checkOutput("tk_pen_ctrl", {14'd0, bus.ADDER_CTRL}, {14'd0, HOLD});
    tick(); bus.BR_REQ = 1'b0;
    bus.LOAD_REQ = 1'b1; bus.LOAD_ADL = 8'h34; bus.LOAD_ADH = 8'h12;
    #1;
    checkOutput("tk_busy", {15'd0, bus.BUSY}, 16'd1);
    checkOutput("tk_add_ctrl", {14'd0, bus.ADDER_CTRL}, {14'd0, ADDC});
    checkOutput("tk_src", {8'd0, bus.ADDER_SRC}, 16'h0005);
    tick(); bus.LOAD_REQ = 1'b0;
    checkOutput("tk_pc", {bus.PCH, bus.PCL}, 16'h8016);
    checkOutput("tk_done", {15'd0, bus.BR_DONE}, 16'd1);
    checkOutput("tk_cross", {15'd0, bus.PAGE_CROSS}, 16'd0);
    checkOutput("tk_busy_end", {15'd0, bus.BUSY}, 16'd0);
    checkOutput("idle_src", {8'd0, bus.ADDER_SRC}, 16'h0000);

    applyStimulus(16'h80F0);
    startBranch(1'b1, 8'h20);
    tick(); bus.BR_REQ = 1'b0;
    tick();
    checkOutput("up_mid_pc", {bus.PCH, bus.PCL}, 16'h8011);
    checkOutput("up_fix_ctrl", {14'd0, bus.ADDER_CTRL}, {14'd0, CADD});
    checkOutput("up_mid_done", {15'd0, bus.BR_DONE}, 16'd0);
    tick();
    checkOutput("up_pc", {bus.PCH, bus.PCL}, 16'h8111);
    checkOutput("up_done", {15'd0, bus.BR_DONE}, 16'd1);
    checkOutput("up_cross", {15'd0, bus.PAGE_CROSS}, 16'd1);
    checkOutput("up_busy", {15'd0, bus.BUSY}, 16'd0);

    applyStimulus(16'h8005);
    startBranch(1'b1, 8'hF0);
    tick(); bus.BR_REQ = 1'b0;
    tick();
    checkOutput("dn_mid_pc", {bus.PCH, bus.PCL}, 16'h80F6);
    checkOutput("dn_fix_ctrl", {14'd0, bus.ADDER_CTRL}, {14'd0, HOLD});
    checkOutput("dn_busy", {15'd0, bus.BUSY}, 16'd1);
    tick();
    checkOutput("dn_pc", {bus.PCH, bus.PCL}, 16'h7FF6);
    checkOutput("dn_done", {15'd0, bus.BR_DONE}, 16'd1);
    checkOutput("dn_cross", {15'd0, bus.PAGE_CROSS}, 16'd1);

    applyStimulus(16'h0005);
    startBranch(1'b1, 8'hF0);
    tick(); bus.BR_REQ = 1'b0;
    tick(); tick();
    checkOutput("dn_wrap_pc", {bus.PCH, bus.PCL}, 16'hFFF6);

    applyStimulus(16'h8080);
    startBranch(1'b1, 8'hF0);
    tick(); bus.BR_REQ = 1'b0;
    tick();
    checkOutput("neg_same_pc", {bus.PCH, bus.PCL}, 16'h8071);
    checkOutput("neg_same_done", {15'd0, bus.BR_DONE}, 16'd1);
    checkOutput("neg_same_cross", {15'd0, bus.PAGE_CROSS}, 16'd0);

    applyStimulus(16'h8010);
    startBranch(1'b1, 8'h05);
    tick(); bus.BR_REQ = 1'b0;
    bus.STEP = 1'b0;
    #1 checkOutput("stall_ctrl", {14'd0, bus.ADDER_CTRL}, {14'd0, HOLD});
    tick(); tick();
    checkOutput("stall_pc", {bus.PCH, bus.PCL}, 16'h8010);
    checkOutput("stall_busy", {15'd0, bus.BUSY}, 16'd1);
    checkOutput("stall_done", {15'd0, bus.BR_DONE}, 16'd0);
    bus.STEP = 1'b1;
    #1 checkOutput("resume_ctrl", {14'd0, bus.ADDER_CTRL}, {14'd0, ADDC});
    tick();
    checkOutput("resume_pc", {bus.PCH, bus.PCL}, 16'h8016);
    checkOutput("resume_done", {15'd0, bus.BR_DONE}, 16'd1);
    bus.STEP = 1'b0;
    tick();
    checkOutput("stall_pulse_clr", {15'd0, bus.BR_DONE}, 16'd0);
    bus.STEP = 1'b1;

    applyStimulus(16'h80F0);
    startBranch(1'b1, 8'h20);
    tick(); bus.BR_REQ = 1'b0;
    tick();
    checkOutput("abort_in_fix", {15'd0, bus.BUSY}, 16'd1);
    RES = 1'b1;
    tick();
    RES = 1'b0;
    #1;
    checkOutput("abort_pc", {bus.PCH, bus.PCL}, 16'hFFFC);
    checkOutput("abort_busy", {15'd0, bus.BUSY}, 16'd0);
    checkOutput("abort_done", {15'd0, bus.BR_DONE}, 16'd0);
    checkOutput("abort_cross", {15'd0, bus.PAGE_CROSS}, 16'd0);
    tick();
    checkOutput("abort_done_after", {15'd0, bus.BR_DONE}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Controller for the mc6502 program-counter adder. It owns the 16-bit PC register and drives the adder's control, source and input operands every cycle. It sequences the adder through increment, absolute load and relative-branch operations, including the two-step page-crossing fix for both forward and backward branches. It sits between the CPU control decoder and the adder, and presents PC to the address-bus mux.

Parameters:
PC_RESET, 16'hFFFC, PC value loaded on reset.
CTRL_HOLD, 2'd0, adder control code: pass-through.
CTRL_INC, 2'd1, adder control code: 16-bit increment.
CTRL_ADD, 2'd2, adder control code: low byte plus 1 plus SRC, carry captured.
CTRL_CADD, 2'd3, adder control code: high byte plus captured carry.

Ports:
CLK  in  1  clock
RES  in  1  synchronous active-high reset
STEP  in  1  advance enable (RDY); when low, all state and PC hold
INC_REQ  in  1  request PC+1
BR_REQ  in  1  relative branch; PC currently addresses the offset byte
BR_COND  in  1  branch condition, sampled with BR_REQ
OFFSET  in  8  signed branch offset, sampled with BR_REQ
LOAD_REQ  in  1  absolute load request
LOAD_ADL  in  8  load value, low byte
LOAD_ADH  in  8  load value, high byte
ADDER_RES_N  out  1  equal to ~RES
ADDER_IL  out  8  equal to PCL
ADDER_IH  out  8  equal to PCH
ADDER_SRC  out  8  latched offset; 8'h00 when not in ADD
ADDER_CTRL  out  2  adder control code
ADDER_OL  in  8  adder result, low byte
ADDER_OH  in  8  adder result, high byte
ADDER_CARRY  in  1  adder carry out
PCL  out  8  PC register, low byte
PCH  out  8  PC register, high byte
BUSY  out  1  high when state is not IDLE
BR_DONE  out  1  one-cycle pulse when a branch completes
PAGE_CROSS  out  1  one-cycle pulse, coincident with BR_DONE, when the branch crossed a page

Behaviour:
- States: IDLE, ADD, FIX.
- Reset: state=IDLE, {PCH,PCL}=PC_RESET, offset register=0, direction register=0, BR_DONE=0, PAGE_CROSS=0. Reset overrides STEP and aborts any branch in flight.
- ADDER_CTRL, ADDER_SRC and BUSY are combinational from state and inputs. PC, BR_DONE and PAGE_CROSS are registered.
- STEP=0: ADDER_CTRL=CTRL_HOLD; no register changes; pulse outputs are forced to 0 for that cycle.
- IDLE with STEP=1 uses priority LOAD_REQ > BR_REQ > INC_REQ:
  - LOAD: CTRL_HOLD; PC <= {LOAD_ADH, LOAD_ADL}.
  - BR_REQ with BR_COND=0: CTRL_INC; PC <= {OH, OL}; BR_DONE pulses next cycle; stay in IDLE.
  - BR_REQ with BR_COND=1: CTRL_HOLD; latch OFFSET; go to ADD. This is the taken-branch penalty cycle.
  - INC_REQ: CTRL_INC; PC <= {OH, OL}. 16'hFFFF wraps to 16'h0000.
  - No request: CTRL_HOLD.
- ADD with STEP=1: CTRL_ADD; SRC = latched offset; PCL <= OL; neg = offset[7].
  - Cross-up when !neg && CARRY. Cross-down when neg && !CARRY.
  - Either cross: record the direction and go to FIX.
  - No cross: pulse BR_DONE and return to IDLE.
- FIX with STEP=1:
  - Up: CTRL_CADD; PCH <= OH.
  - Down: CTRL_HOLD; PCH <= PCH - 1, computed internally with 8-bit wrap (00 becomes FF).
  - Pulse BR_DONE and PAGE_CROSS; return to IDLE.
- Requests arriving in ADD or FIX are ignored and are not queued. The requester must hold them until BUSY=0.
- Branch latency: not taken 1 cycle; taken same-page 2 cycles; taken with page cross 3 cycles. STEP=0 cycles are not counted.

Test Plan:
- Reset: after RES, PC=FFFC, BUSY=0, ADDER_CTRL=HOLD. LOAD ADL=00, ADH=80 -> PC=8000 on the next cycle.
- INC wrap: PC=FFFF with INC_REQ -> PC=0000, CTRL=INC for that cycle.
- Branch not taken: PC=8010, OFFSET=05, COND=0 -> PC=8011 after 1 cycle; BR_DONE pulses; PAGE_CROSS=0.
- Branch taken, same page: PC=8010, OFFSET=05 -> HOLD, then ADD with SRC=05 -> PC=8016; BR_DONE after cycle 2; BUSY high for exactly 1 cycle.
- Cross-up: PC=80F0, OFFSET=20 -> ADD gives PCL=11 with carry; FIX uses CADD -> PC=8111; PAGE_CROSS and BR_DONE pulse. Cross-down: PC=8005, OFFSET=F0 -> PCL=F6 with no carry -> PC=7FF6 in 3 cycles.
- Stall and abort: STEP=0 for 2 cycles during ADD -> PC and state frozen, then resume and give the same result. RES asserted in FIX -> PC=FFFC, IDLE, no BR_DONE pulse.
